// File: rtl/status_flag_unit.sv
// rtl/status_flag_unit.sv - N/Z/C/V status register with saved-flags LIFO
//
// Builds N/Z/C/V from the EX-stage ALU result and holds them in the status
// register. A small LIFO saves flags on exception entry and restores them on
// exception return.
//
// Optional feature macro: FLAG_FWD_EN
//   defined   : flags_cond is the combinational next-flags value (bypass)
//   undefined : flags_cond is the registered flags_reg
//
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   stall                freezes all state (errors included)
//   flush                squashes this cycle's EX flag update only
//   ex_valid, ex_s_bit   EX holds a real instruction / requests flag update
//   ex_logical           1: C<-shifter_c, V kept; 0: C<-alu_c, V<-alu_v
//   alu_result, alu_c, alu_v, shifter_c   ALU/shifter results
//   save, restore        push current flags / pop top entry into flags
//   flags_reg            registered flags {V,C,Z,N}
//   flags_cond           flags presented to the condition tester
//   lifo_count, lifo_full, lifo_empty, lifo_err   LIFO status (err sticky)
module status_flag_unit #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             ex_valid,
    input  logic             ex_s_bit,
    input  logic             ex_logical,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_c,
    input  logic             alu_v,
    input  logic             shifter_c,
    input  logic             save,
    input  logic             restore,
    output logic [3:0]       flags_reg,
    output logic [3:0]       flags_cond,
    output logic [PTR_W-1:0] lifo_count,
    output logic             lifo_full,
    output logic             lifo_empty,
    output logic             lifo_err
);

    localparam logic [PTR_W-1:0] ONE     = PTR_W'(1);
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

    logic [3:0]       flags_q, flags_d;
    logic [PTR_W-1:0] count_q, count_d;
    logic             err_q, err_d;
    logic [3:0]       lifo_q [DEPTH];
    logic [3:0]       lifo_d [DEPTH];

    logic             upd;
    logic             empty, full;
    logic [3:0]       new_flags;
    logic [3:0]       top;
    logic             we;
    logic [PTR_W-1:0] wr_idx;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_P);
    assign upd   = ex_valid & ex_s_bit & ~flush & ~stall;

    // Logical ops keep the current V; C comes from the shifter.
    assign new_flags[0] = alu_result[WIDTH-1];
    assign new_flags[1] = (alu_result == '0);
    assign new_flags[2] = ex_logical ? shifter_c  : alu_c;
    assign new_flags[3] = ex_logical ? flags_q[3] : alu_v;

    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (PTR_W'(i) == count_q - ONE) begin
                top = lifo_q[i];
            end
        end
    end

    always_comb begin
        flags_d = flags_q;
        count_d = count_q;
        err_d   = err_q;
        we      = 1'b0;
        wr_idx  = count_q;
        if (!stall) begin
            if (save && restore && !empty) begin
                // Exchange: old flags overwrite the top, top becomes flags.
                flags_d = top;
                we      = 1'b1;
                wr_idx  = count_q - ONE;
            end else begin
                if (restore && !empty) begin
                    flags_d = top;
                    count_d = count_q - ONE;
                end else if (upd) begin
                    flags_d = new_flags;
                end
                if (restore && empty) begin
                    err_d = 1'b1;
                end
                if (save) begin
                    if (!full) begin
                        // Pushes the pre-edge flags, never this cycle's update.
                        we      = 1'b1;
                        wr_idx  = count_q;
                        count_d = count_q + ONE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            lifo_d[i] = (we && (wr_idx == PTR_W'(i))) ? flags_q : lifo_q[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= 4'b0000;
            count_q <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                lifo_q[i] <= 4'b0000;
            end
        end else begin
            flags_q <= flags_d;
            count_q <= count_d;
            err_q   <= err_d;
            for (int i = 0; i < DEPTH; i++) begin
                lifo_q[i] <= lifo_d[i];
            end
        end
    end

    assign flags_reg  = flags_q;
`ifdef FLAG_FWD_EN
    assign flags_cond = flags_d;
`else
    assign flags_cond = flags_q;
`endif
    assign lifo_count = count_q;
    assign lifo_full  = full;
    assign lifo_empty = empty;
    assign lifo_err   = err_q;

endmodule

// File: tb/tb_status_flag_unit.sv
// tb/tb_status_flag_unit.sv - self-checking bench for status_flag_unit
module tb_status_flag_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, flush, ex_valid, ex_s_bit, ex_logical;
    logic [31:0] alu_result;
    logic        alu_c, alu_v, shifter_c, save, restore;
    logic [3:0]  flags_reg, flags_cond;
    logic [2:0]  lifo_count;
    logic        lifo_full, lifo_empty, lifo_err;

    int checks = 0;
    int errors = 0;

    logic [3:0] sb_q[$];
    logic [3:0] lifo_m[$];
    logic [3:0] exp_f;
    logic [3:0] cur;

    always #5 clk = ~clk;

    status_flag_unit #(.WIDTH(32), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_s_bit(ex_s_bit), .ex_logical(ex_logical),
        .alu_result(alu_result), .alu_c(alu_c), .alu_v(alu_v),
        .shifter_c(shifter_c), .save(save), .restore(restore),
        .flags_reg(flags_reg), .flags_cond(flags_cond),
        .lifo_count(lifo_count), .lifo_full(lifo_full),
        .lifo_empty(lifo_empty), .lifo_err(lifo_err)
    );

    task automatic idle();
        stall = 0; flush = 0; ex_valid = 0; ex_s_bit = 0; ex_logical = 0;
        alu_result = 32'h1; alu_c = 0; alu_v = 0; shifter_c = 0;
        save = 0; restore = 0;
    endtask

    // Drive an S-op whose N/Z/C/V (arith view) is f; f must not have N and Z both set.
    task automatic drive_op(input logic [3:0] f, input logic logical, input logic sc);
        ex_valid = 1; ex_s_bit = 1; ex_logical = logical;
        alu_result = f[0] ? 32'h8000_0000 : (f[1] ? 32'h0 : 32'h0000_0001);
        alu_c = f[2]; alu_v = f[3]; shifter_c = sc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1;
        step();
        reset = 0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        step();
        checks++; if (flags_reg !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", flags_reg); end
        checks++; if (flags_cond !== 4'b0000) begin errors++; $display("FAIL reset_cond got %b exp 0000", flags_cond); end
        checks++; if (lifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", lifo_count); end
        checks++; if ({lifo_empty, lifo_full, lifo_err} !== 3'b100) begin errors++; $display("FAIL reset_status got %b exp 100", {lifo_empty, lifo_full, lifo_err}); end
        reset = 0;
        step();
        checks++; if (flags_reg !== 4'b0000) begin errors++; $display("FAIL post_reset_flags got %b exp 0000", flags_reg); end
    endtask

    task automatic test_arith();
        drive_op(4'b0110, 0, 0); sb_q.push_back(4'b0110);
        step();
        exp_f = sb_q.pop_front();
        checks++; if (flags_reg !== exp_f) begin errors++; $display("FAIL arith_zero got %b exp %b", flags_reg, exp_f); end
        drive_op(4'b0001, 0, 0); sb_q.push_back(4'b0001);
        step();
        exp_f = sb_q.pop_front();
        checks++; if (flags_reg !== exp_f) begin errors++; $display("FAIL arith_neg got %b exp %b", flags_reg, exp_f); end
        drive_op(4'b0110, 0, 0); flush = 1; sb_q.push_back(4'b0001);
        step();
        exp_f = sb_q.pop_front();
        checks++; if (flags_reg !== exp_f) begin errors++; $display("FAIL arith_flush got %b exp %b", flags_reg, exp_f); end
        idle();
    endtask

    task automatic test_logical();
        drive_op(4'b1000, 0, 0); sb_q.push_back(4'b1000);
        step();
        exp_f = sb_q.pop_front();
        checks++; if (flags_reg !== exp_f) begin errors++; $display("FAIL logic_setup got %b exp %b", flags_reg, exp_f); end
        drive_op(4'b0101, 1, 0); sb_q.push_back(4'b1001);
        step();
        exp_f = sb_q.pop_front();
        checks++; if (flags_reg !== exp_f) begin errors++; $display("FAIL logic_vkept got %b exp %b", flags_reg, exp_f); end
        drive_op(4'b0010, 1, 1); sb_q.push_back(4'b1110);
        step();
        exp_f = sb_q.pop_front();
        checks++; if (flags_reg !== exp_f) begin errors++; $display("FAIL logic_shc got %b exp %b", flags_reg, exp_f); end
        idle();
    endtask

    task automatic test_fwd();
        drive_op(4'b0010, 0, 0);
        #1;
`ifdef FLAG_FWD_EN
        exp_f = 4'b0010;
`else
        exp_f = 4'b1110;
`endif
        checks++; if (flags_cond !== exp_f) begin errors++; $display("FAIL cond_same_cycle got %b exp %b", flags_cond, exp_f); end
        step();
        checks++; if (flags_cond !== 4'b0010) begin errors++; $display("FAIL cond_next_cycle got %b exp 0010", flags_cond); end
        checks++; if (flags_reg !== 4'b0010) begin errors++; $display("FAIL fwd_reg got %b exp 0010", flags_reg); end
        drive_op(4'b0101, 0, 0); ex_s_bit = 0;
        step();
        checks++; if (flags_reg !== 4'b0010) begin errors++; $display("FAIL no_sbit got %b exp 0010", flags_reg); end
        drive_op(4'b0101, 0, 0); ex_valid = 0;
        step();
        checks++; if (flags_reg !== 4'b0010) begin errors++; $display("FAIL no_valid got %b exp 0010", flags_reg); end
        drive_op(4'b0101, 0, 0); stall = 1;
        step();
        checks++; if (flags_reg !== 4'b0010) begin errors++; $display("FAIL stall_op got %b exp 0010", flags_reg); end
        idle();
    endtask

    task automatic test_lifo_push();
        logic [3:0] vals [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b1101};
        idle();
        do_reset();
        drive_op(4'b0001, 0, 0);
        step();
        cur = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            drive_op(vals[k], 0, 0); save = 1;
            lifo_m.push_back(cur);
            sb_q.push_back(vals[k]);
            step();
            exp_f = sb_q.pop_front();
            checks++; if (flags_reg !== exp_f) begin errors++; $display("FAIL push_flags%0d got %b exp %b", k, flags_reg, exp_f); end
            checks++; if (lifo_count !== 3'(k + 1)) begin errors++; $display("FAIL push_count%0d got %0d exp %0d", k, lifo_count, k + 1); end
            cur = vals[k];
        end
        checks++; if ({lifo_full, lifo_err} !== 2'b10) begin errors++; $display("FAIL full_noerr got %b exp 10", {lifo_full, lifo_err}); end
        idle(); save = 1;
        step();
        checks++; if ({lifo_count, lifo_full, lifo_err} !== 5'b100_1_1) begin errors++; $display("FAIL overflow got %b exp 10011", {lifo_count, lifo_full, lifo_err}); end
        idle();
    endtask

    task automatic test_lifo_pop();
        for (int k = 0; k < 4; k++) begin
            idle(); restore = 1;
            if (k == 0) drive_op(4'b0010, 0, 0);
            sb_q.push_back(lifo_m.pop_back());
            step();
            exp_f = sb_q.pop_front();
            checks++; if (flags_reg !== exp_f) begin errors++; $display("FAIL pop_flags%0d got %b exp %b", k, flags_reg, exp_f); end
            checks++; if (lifo_count !== 3'(3 - k)) begin errors++; $display("FAIL pop_count%0d got %0d exp %0d", k, lifo_count, 3 - k); end
        end
        checks++; if (lifo_empty !== 1'b1) begin errors++; $display("FAIL pop_empty got %b exp 1", lifo_empty); end
        idle(); restore = 1;
        step();
        checks++; if (flags_reg !== 4'b0001) begin errors++; $display("FAIL underflow_flags got %b exp 0001", flags_reg); end
        checks++; if ({lifo_count, lifo_err} !== 4'b000_1) begin errors++; $display("FAIL underflow_stat got %b exp 0001", {lifo_count, lifo_err}); end
        idle();
    endtask

    task automatic test_async_reset();
        save = 1;
        step();
        step();
        idle();
        checks++; if (lifo_count !== 3'd2) begin errors++; $display("FAIL pre_reset_count got %0d exp 2", lifo_count); end
        #2;
        reset = 1;
        #1;
        checks++; if ({flags_reg, lifo_count, lifo_empty, lifo_err} !== 9'b0000_000_1_0) begin
            errors++; $display("FAIL async_reset got %b exp 000000010", {flags_reg, lifo_count, lifo_empty, lifo_err});
        end
        step();
        reset = 0;
    endtask

    task automatic test_pop_empty();
        drive_op(4'b0101, 0, 0);
        step();
        idle(); restore = 1;
        step();
        checks++; if ({flags_reg, lifo_count, lifo_err} !== 8'b0101_000_1) begin
            errors++; $display("FAIL pop_empty got %b exp 01010001", {flags_reg, lifo_count, lifo_err});
        end
        idle();
    endtask

    task automatic test_exchange();
        do_reset();
        drive_op(4'b0101, 0, 0);
        step();
        idle(); save = 1;
        step();
        drive_op(4'b1010, 0, 0); save = 0;
        step();
        checks++; if (flags_reg !== 4'b1010) begin errors++; $display("FAIL xchg_setup got %b exp 1010", flags_reg); end
        idle(); save = 1; restore = 1;
        step();
        checks++; if ({flags_reg, lifo_count} !== 7'b0101_001) begin errors++; $display("FAIL xchg got %b exp 0101001", {flags_reg, lifo_count}); end
        drive_op(4'b0010, 0, 0); save = 1; restore = 1; stall = 1;
        step();
        checks++; if ({flags_reg, lifo_count, lifo_err} !== 8'b0101_001_0) begin errors++; $display("FAIL xchg_stall got %b exp 01010010", {flags_reg, lifo_count, lifo_err}); end
        idle(); restore = 1;
        step();
        checks++; if ({flags_reg, lifo_count, lifo_err} !== 8'b1010_000_0) begin errors++; $display("FAIL xchg_top got %b exp 10100000", {flags_reg, lifo_count, lifo_err}); end
        idle();
    endtask

    task automatic test_back_to_back();
        logic [3:0] f, prev;
        logic       lg, sc;
        prev = flags_reg === 4'b1010 ? 4'b1010 : 4'bxxxx;
        for (int k = 0; k < 20; k++) begin
            f  = 4'($urandom_range(0, 15));
            if (f[0]) f[1] = 1'b0;
            lg = 1'($urandom_range(0, 1));
            sc = 1'($urandom_range(0, 1));
            drive_op(f, lg, sc);
            exp_f = lg ? {prev[3], sc, f[1], f[0]} : f;
            sb_q.push_back(exp_f);
            prev = exp_f;
            step();
            exp_f = sb_q.pop_front();
            checks++; if (flags_reg !== exp_f) begin errors++; $display("FAIL b2b%0d got %b exp %b", k, flags_reg, exp_f); end
        end
        idle();
    endtask

    initial begin
        idle();
        reset = 1;
        test_reset();
        test_arith();
        test_logical();
        test_fwd();
        test_lifo_push();
        test_lifo_pop();
        test_async_reset();
        test_pop_empty();
        test_exchange();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
